trp_pingpong: RTL

Double-buffered transpose engine for the NPU transpose path. Accepts N-byte rows on a valid/ready write port and returns the transposed tile on a valid/ready read port. Supports 8-, 16- and 32-bit element sizes. Two banks let one tile be filled while the previous tile drains, so streaming proceeds without the stalls of a single-buffer FIFO.

---
 rtl/trp_pkg.sv | 33 +++
 rtl/trp_bank.sv | 53 +++++
 rtl/trp_pingpong.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/trp_pkg.sv
// Shared types and helpers for the trp_pingpong transpose engine.
// TRP_MODE16_EN enables the 16-bit element mode (mode 11).
package trp_pkg;

    typedef enum logic [1:0] {
        BIT8_MODE  = 2'b01,
        BIT32_MODE = 2'b10,
        BIT16_MODE = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        FILLING  = 2'b01,
        FULL     = 2'b10,
        DRAINING = 2'b11
    } bank_state_t;

    localparam logic [2:0] K1 = 3'd1;
    localparam logic [2:0] K2 = 3'd2;
    localparam logic [2:0] K4 = 3'd4;

    // Reserved encodings (00, and 11 without the 16-bit option) fall back to bytes.
    function automatic logic [2:0] mode_to_k(input logic [1:0] m);
        case (m)
            BIT32_MODE: mode_to_k = K4;
`ifdef TRP_MODE16_EN
            BIT16_MODE: mode_to_k = K2;
`endif
            default:    mode_to_k = K1;
        endcase
    endfunction

endpackage

// File: rtl/trp_bank.sv
// One BUFFD x BUFFD byte tile: row write port plus combinational transposed read.
// The k = 2 read path exists only when TRP_MODE16_EN is defined.
module trp_bank
    import trp_pkg::*;
#(
    parameter int BUFFD = 64,
    parameter int AW    = $clog2(BUFFD)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      wr_row_i,
    input  logic [BUFFD*8-1:0] wr_data_i,
    input  logic [AW-1:0]      rd_row_i,
    input  logic [2:0]         k_i,
    output logic [BUFFD*8-1:0] rd_data_o
);

    logic [BUFFD*8-1:0] mem_q [BUFFD];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_row_i] <= wr_data_i;
        end
    end

    // Output byte i comes from stored row i/k, byte r*k + i%k.
    for (genvar i = 0; i < BUFFD; i++) begin : g_col
        logic [BUFFD*8-1:0] src;
        logic [AW-1:0]      idx;

        always_comb begin
            case (k_i)
                K4: begin
                    src = mem_q[i/4];
                    idx = (rd_row_i << 2) | AW'(i % 4);
                end
`ifdef TRP_MODE16_EN
                K2: begin
                    src = mem_q[i/2];
                    idx = (rd_row_i << 1) | AW'(i % 2);
                end
`endif
                default: begin
                    src = mem_q[i];
                    idx = rd_row_i;
                end
            endcase
        end

        assign rd_data_o[8*i +: 8] = src[{idx, 3'b000} +: 8];
    end

endmodule

// File: rtl/trp_pingpong.sv
// Double-buffered (ping-pong) transpose engine for 8/16/32-bit elements.
// Define TRP_MODE16_EN to enable 16-bit elements on mode 11.
module trp_pingpong
    import trp_pkg::*;
#(
    parameter int BUFFD = 64,
    parameter int NBANK = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    input  logic               ffinit,
    input  logic               wvalid,
    output logic               wready,
    input  logic [BUFFD*8-1:0] wdata,
    output logic               rvalid,
    input  logic               rready,
    output logic [BUFFD*8-1:0] rdata,
    output logic               rlast,
    output logic               busy
);

    localparam int AW = $clog2(BUFFD);

    if (NBANK != 2 || BUFFD < 8 || (BUFFD & (BUFFD - 1)) != 0) begin : g_bad_cfg
        $error("trp_pingpong: NBANK must be 2 and BUFFD a power of two >= 8");
    end

    bank_state_t        st_q [2];
    bank_state_t        st_d [2];
    logic [2:0]         k_q [2];
    logic [2:0]         k_d [2];
    logic               wbank_q, wbank_d;
    logic               rbank_q, rbank_d;
    logic [AW-1:0]      wcnt_q, wcnt_d;
    logic [AW-1:0]      rcnt_q, rcnt_d;
    logic               rvalid_q, rvalid_d;
    logic               rlast_q, rlast_d;
    logic [BUFFD*8-1:0] rdata_q, rdata_d;

    logic               wfire;
    logic               rload;
    logic [2:0]         k_w;
    logic               w_last;
    logic               r_last;
    logic [BUFFD*8-1:0] bank_rd [2];

    function automatic logic [AW-1:0] last_row(input logic [2:0] k);
        case (k)
            K4:      last_row = AW'(BUFFD/4 - 1);
`ifdef TRP_MODE16_EN
            K2:      last_row = AW'(BUFFD/2 - 1);
`endif
            default: last_row = AW'(BUFFD - 1);
        endcase
    endfunction

    assign wready = (st_q[wbank_q] == EMPTY) || (st_q[wbank_q] == FILLING);
    assign wfire  = wvalid && wready;
    assign rload  = (!rvalid_q || rready) &&
                    ((st_q[rbank_q] == FULL) || (st_q[rbank_q] == DRAINING));

    // Element size is taken from the mode input only on a tile's first write.
    assign k_w    = (st_q[wbank_q] == EMPTY) ? mode_to_k(mode) : k_q[wbank_q];
    assign w_last = (wcnt_q == last_row(k_w));
    assign r_last = (rcnt_q == last_row(k_q[rbank_q]));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        trp_bank #(
            .BUFFD (BUFFD),
            .AW    (AW)
        ) u_bank (
            .clk       (clk),
            .we_i      (wfire && !ffinit && (wbank_q == 1'(b))),
            .wr_row_i  (wcnt_q),
            .wr_data_i (wdata),
            .rd_row_i  (rcnt_q),
            .k_i       (k_q[b]),
            .rd_data_o (bank_rd[b])
        );
    end

    always_comb begin
        st_d     = st_q;
        k_d      = k_q;
        wbank_d  = wbank_q;
        rbank_d  = rbank_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rdata_d  = rdata_q;

        if (wfire) begin
            k_d[wbank_q] = k_w;
            if (w_last) begin
                st_d[wbank_q] = FULL;
                wcnt_d        = '0;
                wbank_d       = !wbank_q;
            end else begin
                st_d[wbank_q] = FILLING;
                wcnt_d        = wcnt_q + AW'(1);
            end
        end

        // A bank in FULL/DRAINING is never the one being written this cycle.
        if (rload) begin
            rdata_d  = bank_rd[rbank_q];
            rvalid_d = 1'b1;
            rlast_d  = r_last;
            if (r_last) begin
                st_d[rbank_q] = EMPTY;
                rcnt_d        = '0;
                rbank_d       = !rbank_q;
            end else begin
                st_d[rbank_q] = DRAINING;
                rcnt_d        = rcnt_q + AW'(1);
            end
        end else if (rready) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end

        if (ffinit) begin
            st_d     = '{EMPTY, EMPTY};
            k_d      = '{K1, K1};
            wbank_d  = 1'b0;
            rbank_d  = 1'b0;
            wcnt_d   = '0;
            rcnt_d   = '0;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rdata_d  = rdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q     <= '{EMPTY, EMPTY};
            k_q      <= '{K1, K1};
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            st_q     <= st_d;
            k_q      <= k_d;
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign rdata  = rdata_q;
    assign busy   = (st_q[0] != EMPTY) || (st_q[1] != EMPTY) || rvalid_q;

endmodule
